// File: rtl/seq_decoder.sv
// Registered one-hot decoder with direct-load, scanning (up/down with dwell) and hold modes.
// Outputs come straight from registers; only in_ready is combinational.
module seq_decoder #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);
    localparam int N = 2**SEL_W;

    typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN, ST_HOLD} state_t;

    state_t               state_reg;
    state_t               state_next;
    logic                 dir_dn_reg;
    logic                 ctx_reg;
    logic [DWELL_W-1:0]   cnt_reg;
    logic [SEL_W-1:0]     idx_reg;
    logic [N-1:0]         dout_reg;
    logic                 valid_reg;
    logic                 wrap_reg;

    logic [SEL_W-1:0]     idx_step;
    logic                 step_wraps;
    logic                 resume;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        state_next = ST_IDLE;
        if (en) begin
            case (mode)
                2'b00:   state_next = ST_DIRECT;
                2'b11:   state_next = ST_HOLD;
                default: state_next = ST_SCAN;
            endcase
        end
    end

    assign in_ready   = en && (mode == 2'b00);
    assign idx_step   = mode[1] ? idx_reg - 1'b1 : idx_reg + 1'b1;
    assign step_wraps = mode[1] ? (idx_reg == '0) : (idx_reg == {SEL_W{1'b1}});
    // ctx_reg is only alive while in SCAN or HOLD, so a same-direction match means "keep counting".
    assign resume     = ctx_reg && (dir_dn_reg == mode[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            dir_dn_reg <= 1'b0;
            ctx_reg    <= 1'b0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            dout_reg   <= '0;
            valid_reg  <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wrap_reg  <= 1'b0;
            case (state_next)
                ST_IDLE: begin
                    dout_reg  <= '0;
                    valid_reg <= 1'b0;
                    cnt_reg   <= '0;
                    ctx_reg   <= 1'b0;
                end
                ST_DIRECT: begin
                    ctx_reg <= 1'b0;
                    cnt_reg <= '0;
                    if (in_valid) begin
                        idx_reg   <= sel;
                        dout_reg  <= onehot(sel);
                        valid_reg <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!resume) begin
                        // Fresh scan or direction change: restart dwell at the current index.
                        cnt_reg    <= '0;
                        dout_reg   <= onehot(idx_reg);
                        valid_reg  <= 1'b1;
                        dir_dn_reg <= mode[1];
                        ctx_reg    <= 1'b1;
                    end else if (cnt_reg >= dwell) begin
                        cnt_reg   <= '0;
                        idx_reg   <= idx_step;
                        dout_reg  <= onehot(idx_step);
                        valid_reg <= 1'b1;
                        wrap_reg  <= step_wraps;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = valid_reg;
    assign idx        = idx_reg;
    assign wrap       = wrap_reg;
endmodule
